// File: rtl/riscv_trace_buffer.sv
// Retirement-trace capture: circular buffer of {pc, instr, result, cycle} entries that
// runs until a programmable trigger pc has been followed by a post-trigger window.
module riscv_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CW    = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] result_i,
  input  logic            arm_i,
  input  logic            disarm_i,
  input  logic [XLEN-1:0] trig_pc_i,
  input  logic [AW-1:0]   post_cnt_i,
  input  logic            rd_en_i,
  input  logic [AW-1:0]   rd_idx_i,
  output logic            rd_valid_o,
  output logic [XLEN-1:0] rd_pc_o,
  output logic [XLEN-1:0] rd_instr_o,
  output logic [XLEN-1:0] rd_result_o,
  output logic [CW-1:0]   rd_cycle_o,
  output logic [1:0]      state_o,
  output logic [AW:0]     count_o,
  output logic [AW-1:0]   trig_idx_o,
  output logic            done_o
);

  typedef enum logic [1:0] {IDLE = 2'b00, PRE = 2'b01, POST = 2'b10, DONE = 2'b11} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t            state_reg, state_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW:0]       count_reg, count_next, count_inc, trig_calc;
  logic [AW-1:0]     rem_reg, rem_next;
  logic [AW-1:0]     post_reg, post_next;
  logic [XLEN-1:0]   trig_pc_reg, trig_pc_next;
  logic [AW-1:0]     trig_idx_reg, trig_idx_next;
  logic [CW-1:0]     cycle_reg;
  logic              done_reg;
  logic              wr_en;
  logic              rd_ok;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid_reg;

  logic [XLEN-1:0]   pc_mem    [DEPTH];
  logic [XLEN-1:0]   instr_mem [DEPTH];
  logic [XLEN-1:0]   result_mem[DEPTH];
  logic [CW-1:0]     cycle_mem [DEPTH];
  logic [XLEN-1:0]   rd_pc_raw, rd_instr_raw, rd_result_raw;
  logic [CW-1:0]     rd_cycle_raw;

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    rem_next      = rem_reg;
    post_next     = post_reg;
    trig_pc_next  = trig_pc_reg;
    trig_idx_next = trig_idx_reg;
    wr_en         = 1'b0;
    count_inc     = (count_reg == FULL) ? count_reg : count_reg + 1'b1;
    // Trigger position relative to the oldest entry once the final write lands.
    trig_calc     = count_inc - (AW+1)'(1) - {1'b0, post_reg};

    if (disarm_i) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          if (arm_i) begin
            state_next   = PRE;
            wr_ptr_next  = '0;
            count_next   = '0;
            trig_pc_next = trig_pc_i;
            post_next    = post_cnt_i;
          end
        end
        PRE: begin
          if (valid_i) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            count_next  = count_inc;
            if (pc_i == trig_pc_reg) begin
              if (post_reg == '0) begin
                state_next    = DONE;
                trig_idx_next = trig_calc[AW-1:0];
              end else begin
                state_next = POST;
                rem_next   = post_reg;
              end
            end
          end
        end
        POST: begin
          if (valid_i) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            count_next  = count_inc;
            rem_next    = rem_reg - 1'b1;
            if (rem_reg == AW'(1)) begin
              state_next    = DONE;
              trig_idx_next = trig_calc[AW-1:0];
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      rem_reg      <= '0;
      post_reg     <= '0;
      trig_pc_reg  <= '0;
      trig_idx_reg <= '0;
      cycle_reg    <= '0;
      done_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      rem_reg      <= rem_next;
      post_reg     <= post_next;
      trig_pc_reg  <= trig_pc_next;
      trig_idx_reg <= trig_idx_next;
      cycle_reg    <= cycle_reg + 1'b1;
      done_reg     <= (state_next == DONE);
      rd_valid_reg <= rd_ok;
    end
  end

  // Oldest entry sits at wr_ptr once the buffer has wrapped, else at 0.
  assign rd_ok   = rd_en_i && (state_reg == DONE) && ({1'b0, rd_idx_i} < count_reg);
  assign rd_addr = ((count_reg == FULL) ? wr_ptr_reg : '0) + rd_idx_i;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_reg]     <= pc_i;
      instr_mem[wr_ptr_reg]  <= instr_i;
      result_mem[wr_ptr_reg] <= result_i;
      cycle_mem[wr_ptr_reg]  <= cycle_reg;
    end
    rd_pc_raw     <= pc_mem[rd_addr];
    rd_instr_raw  <= instr_mem[rd_addr];
    rd_result_raw <= result_mem[rd_addr];
    rd_cycle_raw  <= cycle_mem[rd_addr];
  end

  assign rd_valid_o  = rd_valid_reg;
  assign rd_pc_o     = rd_valid_reg ? rd_pc_raw     : '0;
  assign rd_instr_o  = rd_valid_reg ? rd_instr_raw  : '0;
  assign rd_result_o = rd_valid_reg ? rd_result_raw : '0;
  assign rd_cycle_o  = rd_valid_reg ? rd_cycle_raw  : '0;
  assign state_o     = state_reg;
  assign count_o     = count_reg;
  assign trig_idx_o  = trig_idx_reg;
  assign done_o      = done_reg;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer (DEPTH=8): queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_riscv_trace_buffer;
  localparam int XLEN = 32, DEPTH = 8, CW = 32, AW = 3;

  logic            clk, reset;
  logic            valid_i, arm_i, disarm_i, rd_en_i;
  logic [XLEN-1:0] pc_i, instr_i, result_i, trig_pc_i;
  logic [AW-1:0]   post_cnt_i, rd_idx_i;
  logic            rd_valid_o, done_o;
  logic [XLEN-1:0] rd_pc_o, rd_instr_o, rd_result_o;
  logic [CW-1:0]   rd_cycle_o;
  logic [1:0]      state_o;
  logic [AW:0]     count_o;
  logic [AW-1:0]   trig_idx_o;

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .result_i(result_i), .arm_i(arm_i), .disarm_i(disarm_i), .trig_pc_i(trig_pc_i),
    .post_cnt_i(post_cnt_i), .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(rd_valid_o), .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o),
    .rd_result_o(rd_result_o), .rd_cycle_o(rd_cycle_o), .state_o(state_o),
    .count_o(count_o), .trig_idx_o(trig_idx_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, res, cyc;
  } ent_t;

  ent_t        q[$];
  int          m_state, m_post, m_rem, m_tidx;
  logic [31:0] m_trig, m_cycle;
  logic        e_rv;
  logic [31:0] e_pc, e_instr, e_res, e_cyc;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0; m_post = 0; m_rem = 0; m_tidx = 0; m_trig = 0; m_cycle = 0;
    e_rv = 0; e_pc = 0; e_instr = 0; e_res = 0; e_cyc = 0;
  endtask

  task automatic model_push();
    q.push_back('{pc_i, instr_i, result_i, m_cycle});
    if (q.size() > DEPTH) void'(q.pop_front());
  endtask

  task automatic model_step();
    if (rd_en_i && m_state == 3 && int'(rd_idx_i) < q.size()) begin
      e_rv = 1; e_pc = q[rd_idx_i].pc; e_instr = q[rd_idx_i].instr;
      e_res = q[rd_idx_i].res; e_cyc = q[rd_idx_i].cyc;
    end else begin
      e_rv = 0; e_pc = 0; e_instr = 0; e_res = 0; e_cyc = 0;
    end
    if (disarm_i) begin
      m_state = 0;
      q.delete();
    end else begin
      case (m_state)
        0, 3: if (arm_i) begin
          m_state = 1; q.delete(); m_trig = trig_pc_i; m_post = int'(post_cnt_i);
        end
        1: if (valid_i) begin
          model_push();
          if (pc_i == m_trig) begin
            if (m_post == 0) begin m_state = 3; m_tidx = q.size() - 1; end
            else begin m_state = 2; m_rem = m_post; end
          end
        end
        default: if (valid_i) begin
          model_push();
          m_rem--;
          if (m_rem == 0) begin m_state = 3; m_tidx = q.size() - 1 - m_post; end
        end
      endcase
    end
    m_cycle++;
  endtask

  always @(posedge clk) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(posedge clk) begin
    #1;
    chk("m_state", state_o, m_state);
    chk("m_count", count_o, q.size());
    chk("m_done", done_o, m_state == 3);
    if (m_state == 3) chk("m_trig_idx", trig_idx_o, m_tidx);
    chk("m_rd_valid", rd_valid_o, e_rv);
    chk("m_rd_pc", rd_pc_o, e_pc);
    chk("m_rd_instr", rd_instr_o, e_instr);
    chk("m_rd_result", rd_result_o, e_res);
    chk("m_rd_cycle", rd_cycle_o, e_cyc);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_arm(input logic [31:0] trig, input int post);
    arm_i = 1; trig_pc_i = trig; post_cnt_i = AW'(post);
    tick();
    arm_i = 0;
  endtask

  task automatic retire(input logic [31:0] pc);
    valid_i = 1; pc_i = pc; instr_i = $urandom; result_i = $urandom;
    tick();
    valid_i = 0;
  endtask

  task automatic rd(input int idx);
    rd_en_i = 1; rd_idx_i = AW'(idx);
    tick();
    rd_en_i = 0;
  endtask

  logic [31:0] c0;

  initial begin
    model_reset();
    reset = 0; valid_i = 0; arm_i = 0; disarm_i = 0; rd_en_i = 0;
    pc_i = 0; instr_i = 0; result_i = 0; trig_pc_i = 0; post_cnt_i = 0; rd_idx_i = 0;
    repeat (3) tick();
    reset = 1;
    chk("rst_state", state_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_done", done_o, 0);

    // Trigger at 0x10 with two post entries.
    do_arm(32'h10, 2);
    for (int i = 0; i < 7; i++) retire(32'(4 * i));
    chk("t1_state", state_o, 3);
    chk("t1_count", count_o, 7);
    chk("t1_trig_idx", trig_idx_o, 4);
    for (int i = 0; i < 7; i++) begin
      rd(i);
      chk("t1_rd_pc", rd_pc_o, 4 * i);
      if (i == 0) c0 = rd_cycle_o;
      else chk("t1_rd_cyc_delta", rd_cycle_o - c0, i);
    end

    // Wrap: 18 entries into an 8-deep buffer.
    do_arm(32'h40, 1);
    for (int i = 0; i < 18; i++) retire(32'(4 * i));
    chk("t2_count", count_o, 8);
    chk("t2_trig_idx", trig_idx_o, 6);
    rd(0); chk("t2_oldest_pc", rd_pc_o, 32'h28);
    rd(7); chk("t2_newest_pc", rd_pc_o, 32'h44);

    // Immediate trigger, no post window.
    do_arm(32'h100, 0);
    retire(32'h100);
    chk("t3_state", state_o, 3);
    chk("t3_count", count_o, 1);
    chk("t3_trig_idx", trig_idx_o, 0);
    rd(1); chk("t3_rd_valid", rd_valid_o, 0); chk("t3_rd_pc", rd_pc_o, 0);

    // Buffer frozen in DONE, then re-arm.
    retire(32'h100);
    chk("t6_count", count_o, 1);
    rd(0); chk("t6_rd_valid", rd_valid_o, 1); chk("t6_rd_pc", rd_pc_o, 32'h100);
    do_arm(32'h200, 0);
    chk("t6_state", state_o, 1);
    chk("t6_count0", count_o, 0);

    // Disarm beats arm in PRE.
    retire(32'h4); retire(32'h8);
    arm_i = 1; disarm_i = 1; tick(); arm_i = 0; disarm_i = 0;
    chk("t4_state", state_o, 0);
    chk("t4_count", count_o, 0);
    retire(32'h200);
    chk("t4_count_idle", count_o, 0);
    rd(0); chk("t4_rd_valid", rd_valid_o, 0);

    // Asynchronous reset while in POST.
    do_arm(32'h8, 3);
    retire(32'h0); retire(32'h4); retire(32'h8); retire(32'hc);
    chk("t5_post", state_o, 2);
    #3 reset = 0;
    #1;
    chk("t5_rst_state", state_o, 0);
    chk("t5_rst_count", count_o, 0);
    chk("t5_rst_done", done_o, 0);
    chk("t5_rst_rdv", rd_valid_o, 0);
    tick(); tick();
    reset = 1;
    do_arm(32'h300, 0);
    retire(32'h300);
    rd(0);
    chk("t5_rd_pc", rd_pc_o, 32'h300);
    chk("t5_cycle_restart", rd_cycle_o, 1);

    // Randomized traffic, including arm in PRE/POST, disarm and brief resets.
    for (int n = 0; n < 3000; n++) begin
      valid_i    = ($urandom % 4) != 0;
      pc_i       = ($urandom % 16) * 4;
      instr_i    = $urandom;
      result_i   = $urandom;
      arm_i      = ($urandom % 6) == 0;
      trig_pc_i  = ($urandom % 16) * 4;
      post_cnt_i = AW'($urandom % 8);
      disarm_i   = ($urandom % 80) == 0;
      rd_en_i    = $urandom % 2;
      rd_idx_i   = AW'($urandom % 8);
      reset      = ($urandom % 400) != 0;
      tick();
    end
    reset = 1; valid_i = 0; arm_i = 0; disarm_i = 0; rd_en_i = 0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Synthesisable retirement-trace capture unit for the RISC-V processor: it records retired instructions into a parametrised circular buffer, stopping on a programmable PC trigger plus a post-trigger window. It replaces simulation-only pc/instr/alu_result monitoring with on-chip capture that can be read back after a run. It sits beside the processor core, fed by a one-cycle retire strobe, and is read by a debug or test harness.

## Interface
- XLEN, 32, width of pc, instruction and result fields
- DEPTH, 16, number of trace entries; power of two, at least 4
- AW, $clog2(DEPTH), index width (derived, not overridden)
- CW, 32, cycle-stamp counter width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- valid_i  in  1  retire strobe, one instruction per cycle when high
- pc_i  in  XLEN  pc of the retiring instruction
- instr_i  in  XLEN  instruction word
- result_i  in  XLEN  alu_result of the instruction
- arm_i  in  1  start capture; samples trig_pc_i and post_cnt_i
- disarm_i  in  1  abort to IDLE
- trig_pc_i  in  XLEN  trigger pc
- post_cnt_i  in  AW  entries captured after the trigger entry
- rd_en_i  in  1  read request
- rd_idx_i  in  AW  read index, 0 = oldest entry
- rd_valid_o  out  1  read data valid
- rd_pc_o, rd_instr_o, rd_result_o  out  XLEN each  entry fields
- rd_cycle_o  out  CW  cycle stamp of entry
- state_o  out  2  00 IDLE, 01 PRE, 10 POST, 11 DONE
- count_o  out  AW+1  valid entries, saturating at DEPTH
- trig_idx_o  out  AW  index (oldest-relative) of the trigger entry; valid in DONE
- done_o  out  1  high in DONE

## Operation
- Reset: state IDLE; wr_ptr, count, post counter, trig_idx, cycle counter = 0; all outputs 0. Buffer contents need not be reset.
- Cycle counter: free-running, increments every cycle after reset, wraps modulo 2^CW.
- IDLE: no capture. arm_i → PRE; clears wr_ptr and count; latches trig_pc_i and post_cnt_i.
- PRE: each valid_i cycle writes {pc_i, instr_i, result_i, cycle} at wr_ptr, and wr_ptr increments modulo DEPTH. count increments, saturating at DEPTH; once full, the oldest entry is overwritten. If valid_i and pc_i == latched trigger pc: the entry is written, then → DONE when latched post count is 0, otherwise → POST with remaining = post count.
- POST: each valid_i writes an entry and decrements remaining; on the write that takes remaining to 0 → DONE.
- DONE: buffer frozen; valid_i ignored. arm_i re-arms (→ PRE, clears as in IDLE).
- disarm_i from any state → IDLE. Contents are kept but count is forced to 0. disarm_i wins over simultaneous arm_i.
- arm_i in PRE or POST is ignored.
- Oldest entry physical address = (count == DEPTH) ? wr_ptr : 0. Read address = oldest + rd_idx_i, modulo DEPTH.
- trig_idx_o = count − 1 − latched post count, computed on DONE entry. Because post_cnt_i ≤ DEPTH−1, the trigger entry is never overwritten.
- Reads are honoured only in DONE with rd_idx_i < count. Otherwise rd_valid_o = 0 and rd data = 0.

## Timing
- Capture: entry written on the rising edge where valid_i = 1. State transition takes effect on the same edge, so a valid_i in the following cycle is already handled under the new state.
- Cycle stamp is the counter value before that edge's increment.
- Read latency: 1 cycle. rd_en_i sampled at edge N; rd_valid_o and data valid after edge N, held for one cycle, then rd_valid_o returns to 0.
- done_o, state_o, count_o, trig_idx_o are registered.
- Reset asserted mid-capture: immediate return to reset values; arm is lost.
- Back-to-back valid_i every cycle is supported, including wrap of wr_ptr from DEPTH−1 to 0.

## Test plan
- DEPTH=8. Reset, then arm with trig_pc=0x10 and post=2; retire pcs 0x0,0x4,…,0x18 every cycle → DONE after 0x18; count=7; trig_idx=4; reads 0..6 give pcs 0x0..0x18 with consecutive cycle stamps.
- DEPTH=8. Arm with trig_pc=0x40 and post=1; retire pcs 0x0..0x44 (18 entries) → count=8; oldest read = pc 0x28; trig_idx=6; idx7 = 0x44 (wrap verified).
- Arm with post=0, and the trigger pc arrives on the first retire → DONE next cycle; count=1; trig_idx=0; rd_idx 1 → rd_valid_o=0, data 0.
- In PRE, assert arm_i and disarm_i together → IDLE; count=0; subsequent valid_i is ignored; read in IDLE → rd_valid_o=0.
- Drop reset to 0 while in POST → all outputs 0 immediately; after release, state IDLE and cycle counter restarts from 0.
- In DONE, a valid_i carrying the trigger pc → count unchanged, buffer unchanged; re-arm → PRE with count=0.
